// File: rtl/branch_history_predictor_pkg.sv
// Shared definitions for the branch history predictor: branch func3 codes,
// clear-sweep FSM states and the counter reset-value helper.
package branch_history_predictor_pkg;

    // Conditional-branch func3 encodings (2 and 3 are illegal)
    localparam logic [2:0] BEQ  = 3'd0;
    localparam logic [2:0] BNE  = 3'd1;
    localparam logic [2:0] BLT  = 3'd4;
    localparam logic [2:0] BGE  = 3'd5;
    localparam logic [2:0] BLTU = 3'd6;
    localparam logic [2:0] BGEU = 3'd7;

    // Widest counter the table supports
    localparam int unsigned MAX_CTR_W = 4;

    typedef enum logic {
        IDLE  = 1'b0,
        SWEEP = 1'b1
    } clr_state_e;

    // Weakly not-taken starting value: 2^(w-1)-1, which is 0 for a 1-bit counter
    function automatic logic [MAX_CTR_W-1:0] ctr_init(input int unsigned ctr_w);
        return MAX_CTR_W'((32'd1 << (ctr_w - 32'd1)) - 32'd1);
    endfunction

endpackage

// File: rtl/branch_history_predictor_if.sv
// Fetch lookup, EX resolution and table-clear signals of the branch history
// predictor.
//   if_pc / if_pred_taken            : fetch-stage lookup
//   ex_* , cf/zf/vf/sf               : EX-stage branch resolution
//   clear_req / clear_busy           : table sweep control
// master = pipeline side, slave = predictor side.
interface branch_history_predictor_if #(
    parameter int unsigned PC_W = 32
);
    logic [PC_W-1:0] if_pc;
    logic            if_pred_taken;
    logic            ex_valid;
    logic            ex_branch;
    logic [PC_W-1:0] ex_pc;
    logic [2:0]      ex_func3;
    logic            cf;
    logic            zf;
    logic            vf;
    logic            sf;
    logic            ex_pred_taken;
    logic            ex_taken;
    logic            ex_mispredict;
    logic            ex_illegal;
    logic            clear_req;
    logic            clear_busy;

    modport master (
        output if_pc, ex_valid, ex_branch, ex_pc, ex_func3,
               cf, zf, vf, sf, ex_pred_taken, clear_req,
        input  if_pred_taken, ex_taken, ex_mispredict, ex_illegal, clear_busy
    );

    modport slave (
        input  if_pc, ex_valid, ex_branch, ex_pc, ex_func3,
               cf, zf, vf, sf, ex_pred_taken, clear_req,
        output if_pred_taken, ex_taken, ex_mispredict, ex_illegal, clear_busy
    );
endinterface

// File: rtl/bhp_sat_counter.sv
// Saturating up/down step of a CTR_W-bit prediction counter.
//   cnt      : current counter value
//   up       : 1 = step up (taken), 0 = step down (not taken)
//   cnt_next : value after one saturating step
module bhp_sat_counter #(
    parameter int unsigned CTR_W = 2
) (
    input  logic [CTR_W-1:0] cnt,
    input  logic             up,
    output logic [CTR_W-1:0] cnt_next
);
    localparam logic [CTR_W-1:0] CTR_MAX = {CTR_W{1'b1}};

    // Hold at the rails, otherwise move one step
    always_comb begin
        cnt_next = cnt;
        if (up && (cnt != CTR_MAX)) begin
            cnt_next = cnt + CTR_W'(1);
        end else if (!up && (cnt != '0)) begin
            cnt_next = cnt - CTR_W'(1);
        end
    end
endmodule

// File: rtl/branch_history_predictor.sv
// Branch direction predictor: a table of saturating counters looked up at
// fetch, branch resolution from ALU flags in EX with mispredict detection,
// training on every legal resolved branch, and a one-entry-per-cycle clear
// sweep.
//   clk, rst_n        : clock, asynchronous active-low reset
//   bus (slave)       : lookup / resolution / clear signals
//   stat_branches     : legal resolved branches     (BHP_STATS_EN only)
//   stat_mispredicts  : mispredicted legal branches (BHP_STATS_EN only)
// Optional feature macro: BHP_STATS_EN.
module branch_history_predictor
    import branch_history_predictor_pkg::*;
#(
    parameter int unsigned ENTRIES = 16,
    parameter int unsigned CTR_W   = 2,
    parameter int unsigned PC_W    = 32
) (
    input  logic        clk,
    input  logic        rst_n,
`ifdef BHP_STATS_EN
    output logic [31:0] stat_branches,
    output logic [31:0] stat_mispredicts,
`endif
    branch_history_predictor_if.slave bus
);
    localparam int unsigned      IDX_W    = $clog2(ENTRIES);
    localparam logic [CTR_W-1:0] INIT_VAL = CTR_W'(ctr_init(CTR_W));

    logic [CTR_W-1:0] table_q [ENTRIES];
    clr_state_e       state_q, state_d;
    logic [IDX_W-1:0] ptr_q, ptr_d;

    logic [IDX_W-1:0] if_idx_c, ex_idx_c;
    logic             resolve_c, legal_c, taken_raw_c, train_en_c;
    logic [CTR_W-1:0] trained_c;

    // PC bits outside the index are intentionally ignored
    logic unused_pc_bits;
    assign unused_pc_bits = ^{bus.if_pc[PC_W-1:IDX_W+2], bus.if_pc[1:0],
                              bus.ex_pc[PC_W-1:IDX_W+2], bus.ex_pc[1:0]};

    assign if_idx_c = bus.if_pc[IDX_W+1:2];
    assign ex_idx_c = bus.ex_pc[IDX_W+1:2];

    // Lookup: counter MSB, suppressed while the table is being cleared
    assign bus.if_pred_taken = (state_q == SWEEP) ? 1'b0 : table_q[if_idx_c][CTR_W-1];
    assign bus.clear_busy    = (state_q == SWEEP);

    // Branch condition from flags; cf is carry-out of a-b (set when a >= b unsigned)
    always_comb begin
        taken_raw_c = 1'b0;
        legal_c     = 1'b1;
        case (bus.ex_func3)
            BEQ:     taken_raw_c = bus.zf;
            BNE:     taken_raw_c = ~bus.zf;
            BLT:     taken_raw_c = bus.sf ^ bus.vf;
            BGE:     taken_raw_c = ~(bus.sf ^ bus.vf);
            BLTU:    taken_raw_c = ~bus.cf;
            BGEU:    taken_raw_c = bus.cf;
            default: legal_c     = 1'b0;
        endcase
    end

    assign resolve_c         = bus.ex_valid & bus.ex_branch;
    assign bus.ex_taken      = resolve_c & legal_c & taken_raw_c;
    assign bus.ex_illegal    = resolve_c & ~legal_c;
    assign bus.ex_mispredict = resolve_c & (bus.ex_taken ^ bus.ex_pred_taken);

    // Training is dropped while the sweep owns the table
    assign train_en_c = resolve_c & legal_c & (state_q == IDLE);

    bhp_sat_counter #(.CTR_W(CTR_W)) u_sat (
        .cnt      (table_q[ex_idx_c]),
        .up       (taken_raw_c),
        .cnt_next (trained_c)
    );

    // Clear FSM state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            ptr_q   <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
        end
    end

    // Clear FSM next state: one entry per SWEEP cycle, requests ignored while sweeping
    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        case (state_q)
            IDLE: begin
                if (bus.clear_req) begin
                    state_d = SWEEP;
                    ptr_d   = '0;
                end
            end
            SWEEP: begin
                ptr_d = ptr_q + IDX_W'(1);
                if (ptr_q == IDX_W'(ENTRIES - 1)) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Counter table
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < int'(ENTRIES); i++) begin
                table_q[i] <= INIT_VAL;
            end
        end else if (state_q == SWEEP) begin
            table_q[ptr_q] <= INIT_VAL;
        end else if (train_en_c) begin
            table_q[ex_idx_c] <= trained_c;
        end
    end

`ifdef BHP_STATS_EN
    logic legal_res_c, legal_misp_c;
    assign legal_res_c  = resolve_c & legal_c;
    assign legal_misp_c = legal_res_c & (taken_raw_c ^ bus.ex_pred_taken);

    // Saturating statistics; a clear request wins over counting
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stat_branches    <= '0;
            stat_mispredicts <= '0;
        end else if (bus.clear_req) begin
            stat_branches    <= '0;
            stat_mispredicts <= '0;
        end else if (legal_res_c) begin
            if (stat_branches != '1) begin
                stat_branches <= stat_branches + 32'd1;
            end
            if (legal_misp_c && (stat_mispredicts != '1)) begin
                stat_mispredicts <= stat_mispredicts + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_branch_history_predictor.sv
// Scoreboard bench for branch_history_predictor: the driver applies one
// instruction per cycle, derives ALU flags from random operands and pushes the
// expected outputs from an array-based reference model; a negedge monitor pops
// and compares.
module tb_branch_history_predictor;
    localparam int unsigned ENTRIES  = 16;
    localparam int unsigned CTR_W    = 2;
    localparam int unsigned PC_W     = 32;
    localparam int          CTR_MAX  = (1 << CTR_W) - 1;
    localparam int          CTR_INIT = (1 << (CTR_W - 1)) - 1;
    localparam int          TAKEN_TH = 1 << (CTR_W - 1);

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    branch_history_predictor_if #(.PC_W(PC_W)) bus ();
`ifdef BHP_STATS_EN
    logic [31:0] stat_branches, stat_mispredicts;
`endif

    branch_history_predictor #(.ENTRIES(ENTRIES), .CTR_W(CTR_W), .PC_W(PC_W)) dut (
        .clk              (clk),
        .rst_n            (rst_n),
`ifdef BHP_STATS_EN
        .stat_branches    (stat_branches),
        .stat_mispredicts (stat_mispredicts),
`endif
        .bus              (bus)
    );

    typedef struct {
        bit          pred;
        bit          taken;
        bit          misp;
        bit          ill;
        bit          busy;
        int unsigned br;
        int unsigned mp;
        string       tag;
    } exp_t;

    exp_t exp_q[$];
    int   compared   = 0;
    int   mismatched = 0;

    // Reference model state
    int          ctr [ENTRIES];
    int          sweep_left;
    int          sweep_ptr;
    int unsigned m_br, m_mp;

    function automatic void check1(string what, string tag, logic [31:0] act, logic [31:0] req);
        compared++;
        if (act !== req) begin
            mismatched++;
            $display("FAIL %s [%s]: got %0h, required %0h", what, tag, act, req);
        end
    endfunction

    function automatic int idx_of(logic [31:0] pc);
        return int'((pc >> 2) % ENTRIES);
    endfunction

    function automatic void model_reset();
        for (int i = 0; i < int'(ENTRIES); i++) ctr[i] = CTR_INIT;
        sweep_left = 0;
        sweep_ptr  = 0;
        m_br       = 0;
        m_mp       = 0;
    endfunction

    // Monitor: compare DUT outputs against the oldest expectation
    exp_t e;
    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check1("if_pred_taken", e.tag, 32'(bus.if_pred_taken), 32'(e.pred));
            check1("ex_taken",      e.tag, 32'(bus.ex_taken),      32'(e.taken));
            check1("ex_mispredict", e.tag, 32'(bus.ex_mispredict), 32'(e.misp));
            check1("ex_illegal",    e.tag, 32'(bus.ex_illegal),    32'(e.ill));
            check1("clear_busy",    e.tag, 32'(bus.clear_busy),    32'(e.busy));
`ifdef BHP_STATS_EN
            check1("stat_branches",    e.tag, stat_branches,    e.br);
            check1("stat_mispredicts", e.tag, stat_mispredicts, e.mp);
`endif
        end
    end

    // One cycle: flags come from the compare a-b, expectation from the comparison itself
    task automatic step(input logic [31:0] ifpc, input bit v, input bit br,
                        input logic [31:0] expc, input logic [2:0] f3,
                        input logic [31:0] a, input logic [31:0] b,
                        input bit pt, input bit clr, input string tag);
        logic [31:0] diff;
        bit   cond, legal, resolve, busy;
        exp_t x;
        int   k;
        diff = a - b;
        bus.if_pc         = ifpc;
        bus.ex_valid      = v;
        bus.ex_branch     = br;
        bus.ex_pc         = expc;
        bus.ex_func3      = f3;
        bus.zf            = (a == b);
        bus.cf            = (a >= b);
        bus.sf            = diff[31];
        bus.vf            = (a[31] != b[31]) && (diff[31] != a[31]);
        bus.ex_pred_taken = pt;
        bus.clear_req     = clr;

        case (f3)
            3'd0: cond = (a == b);
            3'd1: cond = (a != b);
            3'd4: cond = ($signed(a) <  $signed(b));
            3'd5: cond = ($signed(a) >= $signed(b));
            3'd6: cond = (a <  b);
            3'd7: cond = (a >= b);
            default: cond = 1'b0;
        endcase
        legal   = (f3 != 3'd2) && (f3 != 3'd3);
        resolve = v && br;
        busy    = (sweep_left > 0);

        x.pred  = busy ? 1'b0 : (ctr[idx_of(ifpc)] >= TAKEN_TH);
        x.taken = resolve && legal && cond;
        x.ill   = resolve && !legal;
        x.misp  = resolve && (x.taken != pt);
        x.busy  = busy;
        x.br    = m_br;
        x.mp    = m_mp;
        x.tag   = tag;
        exp_q.push_back(x);

        @(posedge clk);
        // Model the effect of this cycle at the edge
        if (busy) begin
            ctr[sweep_ptr] = CTR_INIT;
            sweep_ptr++;
            sweep_left--;
        end else begin
            if (resolve && legal) begin
                k = idx_of(expc);
                if (cond) ctr[k] = (ctr[k] < CTR_MAX) ? ctr[k] + 1 : CTR_MAX;
                else      ctr[k] = (ctr[k] > 0) ? ctr[k] - 1 : 0;
            end
            if (clr) begin
                sweep_left = ENTRIES;
                sweep_ptr  = 0;
            end
        end
        if (clr) begin
            m_br = 0;
            m_mp = 0;
        end else if (resolve && legal) begin
            if (m_br != 32'hFFFF_FFFF) m_br++;
            if ((cond != pt) && (m_mp != 32'hFFFF_FFFF)) m_mp++;
        end
        #1;
    endtask

    task automatic brn(input logic [31:0] pc, input logic [2:0] f3, input logic [31:0] a,
                       input logic [31:0] b, input bit pt, input string tag);
        step(pc, 1'b1, 1'b1, pc, f3, a, b, pt, 1'b0, tag);
    endtask

    task automatic idle(input logic [31:0] pc, input bit clr, input string tag);
        step(pc, 1'b0, 1'b0, 32'h0, 3'd0, 32'h0, 32'h0, 1'b0, clr, tag);
    endtask

    // Asynchronous reset with an immediate check; leaves time at posedge+1
    task automatic do_reset(input string tag);
        rst_n = 1'b0;
        model_reset();
        #1;
        check1("clear_busy_in_reset", tag, 32'(bus.clear_busy), 32'h0);
`ifdef BHP_STATS_EN
        check1("stat_branches_in_reset",    tag, stat_branches,    32'h0);
        check1("stat_mispredicts_in_reset", tag, stat_mispredicts, 32'h0);
`endif
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, required completion");
        $fatal(1);
    end

    initial begin
        bus.if_pc = '0; bus.ex_valid = 0; bus.ex_branch = 0; bus.ex_pc = '0;
        bus.ex_func3 = '0; bus.cf = 0; bus.zf = 0; bus.vf = 0; bus.sf = 0;
        bus.ex_pred_taken = 0; bus.clear_req = 0;
        rst_n = 1'b0;
        #2;
        do_reset("por");

        // Reset defaults, first taken beq mispredicts, then trains to taken
        idle(32'h40, 1'b0, "rst_lookup");
        brn(32'h40, 3'd0, 32'd7, 32'd7, 1'b0, "beq_taken");
        idle(32'h40, 1'b0, "after_train");

        // Saturation at PC 0x100 with taken bne then two not-taken
        for (int i = 0; i < 5; i++) brn(32'h100, 3'd1, 32'd1, 32'd2, 1'b1, "bne_sat");
        idle(32'h100, 1'b0, "sat_lookup");
        brn(32'h100, 3'd1, 32'd3, 32'd3, 1'b1, "bne_nt1");
        idle(32'h100, 1'b0, "nt1_lookup");
        brn(32'h100, 3'd1, 32'd3, 32'd3, 1'b1, "bne_nt2");
        idle(32'h100, 1'b0, "nt2_lookup");

        // Flag decoding and illegal func3
        brn(32'h8, 3'd4, 32'hFFFF_FFFF, 32'd0, 1'b0, "blt_taken");
        brn(32'h8, 3'd4, 32'h8000_0000, 32'd1, 1'b0, "blt_ovf");
        brn(32'h8, 3'd7, 32'd1, 32'd9, 1'b1, "bgeu_nt");
        brn(32'h8, 3'd6, 32'd1, 32'd9, 1'b0, "bltu_taken");
        brn(32'h8, 3'd5, 32'd4, 32'd4, 1'b0, "bge_eq");
        brn(32'h8, 3'd2, 32'd4, 32'd4, 1'b1, "illegal2");
        brn(32'h8, 3'd3, 32'd4, 32'd5, 1'b0, "illegal3");
        idle(32'h8, 1'b0, "illegal_lookup");

        // Aliasing: 0x000 and 0x040 share an entry
        brn(32'h000, 3'd0, 32'd0, 32'd1, 1'b0, "alias_nt");
        idle(32'h040, 1'b0, "alias_lookup1");
        brn(32'h000, 3'd0, 32'd5, 32'd5, 1'b0, "alias_t1");
        brn(32'h000, 3'd0, 32'd5, 32'd5, 1'b0, "alias_t2");
        idle(32'h040, 1'b0, "alias_lookup2");

        // Clear sweep: train entry 3, sweep with taken branches, read back
        for (int i = 0; i < 3; i++) brn(32'h0C, 3'd1, 32'd1, 32'd0, 1'b1, "train3");
        step(32'h0C, 1'b0, 1'b0, 32'h0, 3'd0, 32'd0, 32'd0, 1'b0, 1'b1, "clear_pulse");
        for (int i = 0; i < int'(ENTRIES); i++) begin
            step(32'h0C, 1'b1, 1'b1, 32'h0C, 3'd1, 32'd1, 32'd0, 1'b1, (i == 4), "sweep");
        end
        idle(32'h0C, 1'b0, "post_sweep");
        brn(32'h0C, 3'd1, 32'd1, 32'd0, 1'b0, "post_train");
        idle(32'h0C, 1'b0, "post_train_lookup");

        // Reset in the middle of a sweep
        for (int i = 0; i < 3; i++) brn(32'h14, 3'd0, 32'd2, 32'd2, 1'b0, "pre_sweep2");
        idle(32'h14, 1'b1, "clear2");
        for (int i = 0; i < 5; i++) idle(32'h14, 1'b0, "sweep2");
        do_reset("mid_sweep");
        for (int i = 0; i < int'(ENTRIES); i++) begin
            brn(32'(i * 4), 3'd0, 32'd1, 32'd1, 1'b0, "post_rst_train");
            idle(32'(i * 4), 1'b0, "post_rst_lookup");
        end

        // Randomised traffic
        for (int n = 0; n < 400; n++) begin
            logic [31:0] a, b, pc, ipc;
            a   = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 8)) : $urandom();
            b   = ($urandom_range(0, 3) == 0) ? a : (($urandom_range(0, 1) == 1) ? $urandom() : 32'($urandom_range(0, 8)));
            pc  = 32'(($urandom_range(0, 15) << 2) | ($urandom_range(0, 3) << 6));
            ipc = ($urandom_range(0, 1) == 1) ? pc : 32'($urandom() & 32'h0000_0FFC);
            step(ipc, ($urandom_range(0, 7) != 0), ($urandom_range(0, 4) != 0), pc,
                 3'($urandom_range(0, 7)), a, b, 1'($urandom_range(0, 1)),
                 ($urandom_range(0, 59) == 0), "random");
        end

        @(negedge clk);
        #1;
        check1("scoreboard_drain", "end", 32'(exp_q.size()), 32'h0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
